// File: rtl/apb_mem_slave.sv
// -----------------------------------------------------------------------------
// apb_mem_slave
//
// APB leaf slave with an integrated DEPTH x DATA_WIDTH synchronous memory.
// Each APB transfer is turned into a request on an internal memory port.
// PREADY is withheld until that memory reports completion. The memory takes
// MEM_LATENCY request cycles, so a transfer has MEM_LATENCY APB wait states.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst_n      : asynchronous active-low reset (clears FSM, outputs and memory)
//   id         : static slave index strap, not used by the datapath
//   sel        : APB PSEL
//   enable     : APB PENABLE
//   write      : 1 = write, 0 = read
//   addr       : byte address
//   wdata      : write data
//   rdata      : last completed read data
//   ready      : APB PREADY
//   state      : FSM state (0 IDLE, 1 REQ, 2 WAIT), for debug
//   mem_ce     : memory request active
//   mem_wren   : memory write request
//   mem_rden   : memory read request
//   mem_ready  : memory completion flag (registered)
// -----------------------------------------------------------------------------
module apb_mem_slave #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 2 ** ADDR_WIDTH,
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            id,
   input  logic                  sel,
   input  logic                  enable,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  ready,
   output logic [2:0]            state,
   output logic                  mem_ce,
   output logic                  mem_wren,
   output logic                  mem_rden,
   output logic                  mem_ready
);

   // Counter must be able to hold the value MEM_LATENCY.
   localparam int CNT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2
   } state_t;

   state_t                state_q;
   state_t                state_d;

   logic [ADDR_WIDTH-1:0] addr_l;
   logic [DATA_WIDTH-1:0] wdata_l;
   logic                  write_l;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_next;
   logic                  mem_ready_q;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  setup_seen;
   logic                  access_done;

   // The strap carries no function here; folded away so it is not left dangling.
   logic                  id_unused;
   assign id_unused = ^id;

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state and memory-port / APB outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      mem_ce   = 1'b0;
      mem_wren = 1'b0;
      mem_rden = 1'b0;
      ready    = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Only a genuine setup phase (sel without enable) starts a transfer.
            if (sel && !enable) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            mem_ce   = 1'b1;
            mem_wren = write_l;
            mem_rden = ~write_l;
            state_d  = sel ? S_WAIT : S_IDLE;
         end
         S_WAIT: begin
            mem_ce   = 1'b1;
            mem_wren = write_l;
            mem_rden = ~write_l;
            ready    = mem_ready_q & sel & enable;
            if (!sel || ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign setup_seen = (state_q == S_IDLE) && sel && !enable;

   // Request cycles are counted from REQ; the access happens on the edge that
   // ends the MEM_LATENCY-th one. Requiring sel means an aborting edge never
   // commits a write.
   assign cnt_next    = (state_q == S_REQ) ? CNT_W'(1) : cnt + CNT_W'(1);
   assign access_done = mem_ce && sel && !mem_ready_q &&
                        (cnt_next == CNT_W'(MEM_LATENCY));

   // ---------------------------------------------------------------------------
   // Transfer latches, latency counter and memory array
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_l      <= '0;
         wdata_l     <= '0;
         write_l     <= 1'b0;
         cnt         <= '0;
         mem_ready_q <= 1'b0;
         mem_rdata   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (setup_seen) begin
            addr_l  <= addr;
            wdata_l <= wdata;
            write_l <= write;
         end

         if (state_d == S_IDLE) begin
            // Completion, abort or idle: drop any pending request.
            cnt         <= '0;
            mem_ready_q <= 1'b0;
         end else if (mem_ce && sel && !mem_ready_q) begin
            cnt <= cnt_next;
            if (access_done) begin
               mem_ready_q <= 1'b1;
               if (write_l) begin
                  mem[addr_l] <= wdata_l;
               end else begin
                  mem_rdata <= mem[addr_l];
               end
            end
         end
      end
   end

   assign mem_ready = mem_ready_q;
   assign rdata     = mem_rdata;
   assign state     = state_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_mem_slave
//
// Directed bench for apb_mem_slave. Two instances share the APB bus wires
// except for sel: u1 has MEM_LATENCY=1 and u3 has MEM_LATENCY=3.
// -----------------------------------------------------------------------------
module tb_apb_mem_slave;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] id = 2'd1;
   logic       sel1, sel3;
   logic       enable;
   logic       write;
   logic [7:0] addr;
   logic [7:0] wdata;

   logic [7:0] rdata1, rdata3;
   logic       ready1, ready3;
   logic [2:0] state1, state3;
   logic       ce1, wren1, rden1, mrdy1;
   logic       ce3, wren3, rden3, mrdy3;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   apb_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256), .MEM_LATENCY(1)) u1 (
      .clk(clk), .rst_n(rst_n), .id(id), .sel(sel1), .enable(enable),
      .write(write), .addr(addr), .wdata(wdata), .rdata(rdata1),
      .ready(ready1), .state(state1), .mem_ce(ce1), .mem_wren(wren1),
      .mem_rden(rden1), .mem_ready(mrdy1)
   );

   apb_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256), .MEM_LATENCY(3)) u3 (
      .clk(clk), .rst_n(rst_n), .id(id), .sel(sel3), .enable(enable),
      .write(write), .addr(addr), .wdata(wdata), .rdata(rdata3),
      .ready(ready3), .state(state3), .mem_ce(ce3), .mem_wren(wren3),
      .mem_rden(rden3), .mem_ready(mrdy3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic ready_of(input int which);
      return (which == 0) ? ready1 : ready3;
   endfunction

   function automatic logic [7:0] rdata_of(input int which);
      return (which == 0) ? rdata1 : rdata3;
   endfunction

   task automatic set_sel(input int which, input logic v);
      if (which == 0) sel1 = v;
      else            sel3 = v;
   endtask

   // Call 1 time unit after a rising edge. Drives the setup phase at once,
   // then the access phase; returns just after the completion edge with sel
   // still high so a following call is a true back-to-back transfer.
   task automatic xfer(input int which, input logic wr, input logic [7:0] a,
                       input logic [7:0] d, output logic [7:0] rd,
                       output int waits, output logic ok);
      set_sel(which, 1'b1);
      enable = 1'b0;
      write  = wr;
      addr   = a;
      wdata  = d;
      rd     = 8'hxx;
      waits  = 0;
      ok     = 1'b0;
      @(posedge clk); #1;
      enable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ready_of(which)) begin
            ok = 1'b1;
            rd = rdata_of(which);
            break;
         end
         waits++;
      end
      @(posedge clk); #1;
   endtask

   task automatic go_idle();
      sel1   = 1'b0;
      sel3   = 1'b0;
      enable = 1'b0;
      @(posedge clk); #1;
   endtask

   // Setup a write, then withdraw sel during the REQ cycle.
   task automatic abort_write(input int which, input logic [7:0] a, input logic [7:0] d);
      set_sel(which, 1'b1);
      enable = 1'b0;
      write  = 1'b1;
      addr   = a;
      wdata  = d;
      @(posedge clk); #1;
      set_sel(which, 1'b0);
      @(negedge clk);
      check($sformatf("abort_req_state_%0d", which),
            (which == 0) ? state1 : state3, 3'd1);
      check($sformatf("abort_req_ready_%0d", which), ready_of(which), 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("abort_idle_state_%0d", which),
            (which == 0) ? state1 : state3, 3'd0);
      check($sformatf("abort_idle_ready_%0d", which), ready_of(which), 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] rd;
      int         w;
      logic       ok;

      rst_n  = 1'b0;
      sel1   = 1'b0;
      sel3   = 1'b0;
      enable = 1'b0;
      write  = 1'b0;
      addr   = 8'h00;
      wdata  = 8'h00;

      // Reset values
      #12;
      check("rst_ready", ready1, 1'b0);
      check("rst_rdata", rdata1, 8'h00);
      check("rst_state", state1, 3'd0);
      check("rst_ce",    ce1,    1'b0);
      check("rst_wren",  wren1,  1'b0);
      check("rst_rden",  rden1,  1'b0);
      check("rst_mrdy",  mrdy1,  1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      xfer(0, 1'b0, 8'h06, 8'h00, rd, w, ok);
      go_idle();
      check("rst_read_ok",   ok, 1'b1);
      check("rst_read_data", rd, 8'h00);
      check("rst_read_wait", w,  1);

      // Write 0x05 to 0x06 on the latency-1 slave, phase by phase
      sel1 = 1'b1; write = 1'b1; addr = 8'h06; wdata = 8'h05; enable = 1'b0;
      @(negedge clk);
      check("wr_c0_state", state1, 3'd0);
      @(posedge clk); #1;
      enable = 1'b1;
      @(negedge clk);
      check("wr_c1_state", state1, 3'd1);
      check("wr_c1_ce",    ce1,    1'b1);
      check("wr_c1_wren",  wren1,  1'b1);
      check("wr_c1_rden",  rden1,  1'b0);
      check("wr_c1_ready", ready1, 1'b0);
      @(negedge clk);
      check("wr_c2_state", state1, 3'd2);
      check("wr_c2_ready", ready1, 1'b1);
      @(posedge clk); #1;
      sel1 = 1'b0; enable = 1'b0;
      @(negedge clk);
      check("wr_end_state", state1, 3'd0);
      check("wr_end_ce",    ce1,    1'b0);

      // Read it back
      @(posedge clk); #1;
      sel1 = 1'b1; write = 1'b0; addr = 8'h06; enable = 1'b0;
      @(posedge clk); #1;
      enable = 1'b1;
      @(negedge clk);
      check("rd_c1_ce",    ce1,    1'b1);
      check("rd_c1_rden",  rden1,  1'b1);
      check("rd_c1_wren",  wren1,  1'b0);
      check("rd_c1_ready", ready1, 1'b0);
      @(negedge clk);
      check("rd_c2_ready", ready1, 1'b1);
      check("rd_c2_rdata", rdata1, 8'h05);
      @(posedge clk); #1;
      sel1 = 1'b0; enable = 1'b0;
      @(negedge clk);
      check("rd_hold_rdata", rdata1, 8'h05);
      check("rd_hold_state", state1, 3'd0);

      // enable without a setup phase is ignored
      sel1 = 1'b1; enable = 1'b1; write = 1'b1; addr = 8'h30; wdata = 8'h33;
      @(posedge clk); #1;
      @(negedge clk);
      check("noset_state", state1, 3'd0);
      check("noset_ready", ready1, 1'b0);
      sel1 = 1'b0; enable = 1'b0;
      @(posedge clk); #1;
      xfer(0, 1'b0, 8'h30, 8'h00, rd, w, ok);
      go_idle();
      check("noset_mem", rd, 8'h00);

      // Latency 3, back-to-back write/read/read, top and bottom addresses
      xfer(1, 1'b1, 8'hFF, 8'hA5, rd, w, ok);
      check("lat_wr_ok",   ok, 1'b1);
      check("lat_wr_wait", w,  3);
      xfer(1, 1'b0, 8'hFF, 8'h00, rd, w, ok);
      check("lat_rdff_wait", w,  3);
      check("lat_rdff_data", rd, 8'hA5);
      xfer(1, 1'b0, 8'h00, 8'h00, rd, w, ok);
      check("lat_rd00_wait", w,  3);
      check("lat_rd00_data", rd, 8'h00);
      check("lat_rd00_hold", rdata3, 8'h00);
      go_idle();

      // Abort in REQ on both latencies; the write must not land
      abort_write(1, 8'h10, 8'h77);
      xfer(1, 1'b0, 8'h10, 8'h00, rd, w, ok);
      go_idle();
      check("abort_mem_3", rd, 8'h00);
      abort_write(0, 8'h11, 8'h77);
      xfer(0, 1'b0, 8'h11, 8'h00, rd, w, ok);
      go_idle();
      check("abort_mem_1", rd, 8'h00);

      // Asynchronous reset in the middle of a WAIT
      sel3 = 1'b1; write = 1'b1; addr = 8'h20; wdata = 8'h5A; enable = 1'b0;
      @(posedge clk); #1;
      enable = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("areset_pre_state", state3, 3'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_state", state3, 3'd0);
      check("areset_ready", ready3, 1'b0);
      check("areset_ce",    ce3,    1'b0);
      check("areset_rdata", rdata3, 8'h00);
      sel3 = 1'b0; enable = 1'b0;
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      xfer(1, 1'b0, 8'hFF, 8'h00, rd, w, ok);
      check("areset_memff", rd, 8'h00);
      xfer(1, 1'b0, 8'h20, 8'h00, rd, w, ok);
      check("areset_mem20", rd, 8'h00);
      go_idle();
      xfer(0, 1'b0, 8'h06, 8'h00, rd, w, ok);
      go_idle();
      check("areset_mem06", rd, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not reach its end");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- 8-bit APB slave with an integrated 256x8 synchronous memory. It sits behind the APB bus fabric as a leaf peripheral.
- Every APB transfer is converted into a request on an internal memory port (ce/wren/rden/ready). The APB ready output is held off until the memory signals completion.
- Memory latency is parameterised, so the block exercises APB wait states.

Parameters:
- ADDR_WIDTH  8  APB/memory address width.
- DATA_WIDTH  8  APB/memory data width.
- DEPTH  256  memory locations (2**ADDR_WIDTH).
- MEM_LATENCY  1  memory cycles from request to completion (>=1); equals the number of APB wait states.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id  in  2  static slave index strap; no effect on datapath; must be stable.
- sel  in  1  APB select (PSEL).
- enable  in  1  APB enable (PENABLE).
- write  in  1  1=write, 0=read.
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  DATA_WIDTH  write data.
- rdata  out  DATA_WIDTH  read data; valid when ready=1 on a read.
- ready  out  1  APB ready (PREADY); transfer completes on a clk edge with sel&enable&ready.
- state  out  3  FSM state, for debug.
- mem_ce, mem_wren, mem_rden, mem_ready  out  1 each  internal memory port, exported for observation.

Behaviour:
- Reset (rst_n=0, async), effective immediately:
  - state=IDLE; ready=0; rdata=0.
  - mem_ce, mem_wren, mem_rden and mem_ready all 0.
  - Latency counter=0; all memory locations cleared to 0x00.
- IDLE (0):
  - No memory request.
  - Edge with sel=1 & enable=0 (setup phase): latch addr, wdata and write; go to REQ.
- REQ (1): first access cycle.
  - Drive mem_ce=1 and mem_wren=write_l; mem_rden=~write_l.
  - Start the latency counter; ready=0.
  - Next edge: go to WAIT.
- WAIT (2):
  - mem_ce and wren/rden held; counter increments each cycle.
  - Memory sets mem_ready (registered) at the edge ending the MEM_LATENCY-th request cycle (counted from REQ).
  - At that same edge: a read loads mem_rdata <= mem[addr_l]; a write commits mem[addr_l] <= wdata_l.
  - ready = (state==WAIT) & mem_ready & sel & enable, combinational.
  - rdata = mem_rdata register; it holds the last read value until the next read completes.
  - On an edge with ready=1: go to IDLE and clear mem_ready, mem_ce, wren and rden.
- Timing with MEM_LATENCY=1, cycles C0..C2:
  - C0: setup phase, state=IDLE.
  - C1: enable=1, state=REQ, ce=1, ready=0.
  - C2: state=WAIT, ready=1, transfer ends.
- General timing: MEM_LATENCY wait cycles (enable=1, ready=0), then one ready cycle.
- Back-to-back transfers: the master's new setup phase is the cycle after completion. It is seen in IDLE, so no extra gap is inserted.
- Abort: if sel=0 during REQ/WAIT, return to IDLE next edge and drop the memory request.
  - A write not yet committed is discarded; a committed one stays.
- enable=1 without a preceding setup while in IDLE: ignored, stays IDLE, ready=0.
- Address range: full 0..DEPTH-1, no decode error and no wrap beyond 0xFF; locations are independent.
- Reset asserted mid-transfer: immediate return to IDLE with memory cleared, per the reset rules above.
- Encodings 3..7 are unused; any illegal state recovers to IDLE.

Test Plan:
- Reset: rst_n=0 then 1 -> ready=0, rdata=0x00, state=0, ce/wren/rden=0; a subsequent read of addr 0x06 returns 0x00.
- Write: C0 sel=1 write=1 addr=0x06 wdata=0x05, C1 enable=1 -> C1 state=1 ce=1 wren=1 ready=0; C2 ready=1; then sel=enable=0 -> state=0.
- Read-back: C0 sel=1 write=0 addr=0x06, C1 enable=1 -> C1 ce=1 rden=1 ready=0; C2 ready=1 rdata=0x05; rdata still 0x05 after sel drops.
- Latency and back-to-back: with MEM_LATENCY=3, write 0xA5 to 0xFF then immediately read 0xFF and 0x00.
  - Each transfer shows exactly 3 wait cycles.
  - The reads return 0xA5 and 0x00.
- Abort: write 0x77 to 0x10, drop sel in the REQ cycle -> state=0 next edge, ready never 1; a read of 0x10 returns 0x00.
- Async reset mid-WAIT: rst_n low between edges -> state=0, ready=0 without waiting for a clock edge; memory reads 0x00 afterwards.
